// File: rtl/segway_pkg.sv
// Shared types and constants for the rider / steer-enable logic.
package segway_pkg;

    localparam int unsigned LD_W  = 12;
    localparam int unsigned SUM_W = 13;

    // Rider-present threshold on lft_ld + rght_ld, and the hysteresis band around it
    localparam logic [LD_W-1:0] MIN_RIDER_WT_DEF = 12'h200;
    localparam logic [LD_W-1:0] WT_HYST_DEF      = 12'h040;

    // Settle timer width: 26 bits is ~1.34 s at 50 MHz; 8 bits keeps simulations short
    localparam int unsigned TMR_BITS_DEF = 26;
    localparam int unsigned TMR_BITS_SIM = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        STEER_EN = 2'd2
    } steer_state_e;

    // Unsigned magnitude of the difference between two load-cell readings
    function automatic logic [LD_W-1:0] abs_diff(input logic [LD_W-1:0] a,
                                                 input logic [LD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/rider_steer_en_settle_tmr.sv
// settle_tmr: saturating up-counter used to require the rider to stand still.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear to zero (wins over en_i)
//   en_i     : count enable
//   full_c   : combinational, counter is all ones
//   cnt_o    : current count
module settle_tmr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic         full_c,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign full_c = &cnt_q;
    assign cnt_o  = cnt_q;

    // Saturate at all ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !full_c) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rider_steer_en.sv
// rider_steer_en: decides from each load-cell pair whether a rider is present
// and balanced long enough to allow steering.
//   clk, rst  : clock, synchronous active-high reset
//   ld_vld    : strobe, lft_ld/rght_ld hold a new conversion pair
//   lft_ld    : left load cell, unsigned
//   rght_ld   : right load cell, unsigned
//   en_steer  : registered, steering enabled (state STEER_EN)
//   rider_off : registered, no rider present (state IDLE)
//   ld_sum    : latched lft_ld + rght_ld
module rider_steer_en
    import segway_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DEF,
    parameter logic [11:0] WT_HYST      = WT_HYST_DEF,
    parameter int unsigned TMR_BITS     = TMR_BITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_vld,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off,
    output logic [12:0] ld_sum
);

    localparam logic [SUM_W-1:0] HI_THR = SUM_W'(MIN_RIDER_WT) + SUM_W'(WT_HYST);
    localparam logic [SUM_W-1:0] LO_THR = SUM_W'(MIN_RIDER_WT) - SUM_W'(WT_HYST);

    logic [SUM_W-1:0] ld_sum_q,  ld_sum_d;
    logic [LD_W-1:0]  ld_diff_q, ld_diff_d;
    steer_state_e     state_q,   state_d;
    logic             en_steer_q,  en_steer_d;
    logic             rider_off_q, rider_off_d;

    logic sum_gt_min_c;
    logic sum_lt_min_c;
    logic diff_gt_1_4_c;
    logic diff_gt_15_16_c;
    logic tmr_clr_c;
    logic tmr_en_c;
    logic tmr_full_c;
    logic [TMR_BITS-1:0] tmr_cnt;

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;
    assign ld_sum    = ld_sum_q;

    // Stage 1: capture sum and difference of each new pair
    always_comb begin
        ld_sum_d  = ld_sum_q;
        ld_diff_d = ld_diff_q;
        if (ld_vld) begin
            ld_sum_d  = SUM_W'(lft_ld) + SUM_W'(rght_ld);
            ld_diff_d = abs_diff(lft_ld, rght_ld);
        end
    end

    // Stage 2: threshold and balance flags
    always_comb begin
        sum_gt_min_c    = ld_sum_q > HI_THR;
        sum_lt_min_c    = ld_sum_q < LO_THR;
        diff_gt_1_4_c   = SUM_W'(ld_diff_q) > (ld_sum_q >> 2);
        diff_gt_15_16_c = SUM_W'(ld_diff_q) > (ld_sum_q - (ld_sum_q >> 4));
    end

    // Next state and registered outputs derived from it
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sum_gt_min_c) state_d = WAIT;
            end
            WAIT: begin
                if (sum_lt_min_c)        state_d = IDLE;
                else if (diff_gt_1_4_c)  state_d = WAIT;
                else if (tmr_full_c)     state_d = STEER_EN;
            end
            STEER_EN: begin
                if (sum_lt_min_c)          state_d = IDLE;
                else if (diff_gt_15_16_c)  state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
        en_steer_d  = (state_d == STEER_EN);
        rider_off_d = (state_d == IDLE);
    end

    // Timer restarts on every entry to WAIT and whenever the rider shifts weight in WAIT
    assign tmr_clr_c = ((state_q != WAIT) && (state_d == WAIT)) ||
                       ((state_q == WAIT) && diff_gt_1_4_c);
    assign tmr_en_c  = (state_q == WAIT);

    settle_tmr #(
        .W (TMR_BITS)
    ) u_tmr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tmr_clr_c),
        .en_i   (tmr_en_c),
        .full_c (tmr_full_c),
        .cnt_o  (tmr_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_sum_q    <= '0;
            ld_diff_q   <= '0;
            state_q     <= IDLE;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
        end else begin
            ld_sum_q    <= ld_sum_d;
            ld_diff_q   <= ld_diff_d;
            state_q     <= state_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^tmr_cnt;

endmodule
